req_ack_checker: RTL and testbench

- Synthesizable monitor for one req/ack handshake, clocked by the global clock.
- Assertion: req at sample n requires ack at sample n+1. The attempt is accepted (aborted as pass) if interrupt is high at sample n or n+1.
- Cover: one or more consecutive req samples followed by ack on the next sample.
- Instantiated beside the handshake under observation; outputs pulses and saturating counters for status logic.

---
 rtl/req_ack_checker_pkg.sv | 20 ++
 rtl/req_ack_checker_if.sv | 13 +
 rtl/req_ack_checker_sat_counter.sv | 33 +++
 rtl/req_ack_checker.sv | 114 +++++++++++
 tb/tb_req_ack_checker.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/req_ack_checker_pkg.sv
// req_ack_checker_pkg: shared constants and types for the req/ack checker.
// Default counter widths, the per-sample outcome of a pending attempt, and a
// helper that turns two simultaneous one-bit events into a 2-bit increment.
package req_ack_checker_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int RUN_W_DEF = 8;

    typedef enum logic [1:0] {
        NONE,
        PASS,
        FAIL,
        ABORT
    } resolution_e;

    function automatic logic [1:0] event_count(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/req_ack_checker_if.sv
// req_ack_checker_if: the observed handshake plus the checker enable and the
// abort condition. The master side drives them; the checker only listens.
interface req_ack_checker_if;

    logic en;
    logic req;
    logic ack;
    logic intr;

    modport master (output en, req, ack, intr);
    modport slave  (input  en, req, ack, intr);

endinterface

// File: rtl/req_ack_checker_sat_counter.sv
// sat_counter: W-bit counter that adds 0..2 per cycle and sticks at all-ones.
// clr and rst both return it to zero; clr takes priority over inc.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   inc,
    input  logic         clr,
    output logic [W-1:0] value
);

    localparam logic [W:0] MAX = {1'b0, {W{1'b1}}};

    logic [W:0] sum;

    // One extra bit of headroom so an overflow is visible before clamping.
    always_comb begin
        sum = {1'b0, value} + (W+1)'(inc);
    end

    // Clear on reset/clr, otherwise add and clamp at the maximum.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= '0;
        end else if (sum > MAX) begin
            value <= {W{1'b1}};
        end else begin
            value <= sum[W-1:0];
        end
    end

endmodule

// File: rtl/req_ack_checker.sv
// req_ack_checker: monitors "req at n implies ack at n+1" (aborted as a pass
// when intr is high at n or n+1) and covers "one or more req then ack".
// Optional macro REQ_ACK_CHECKER_FAIL_LOG_EN adds a first-failure cycle log.
module req_ack_checker
    import req_ack_checker_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int RUN_W = RUN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    req_ack_checker_if.slave  hs,
    output logic              assert_fail_o,
    output logic              assert_pass_o,
    output logic              cover_hit_o,
    output logic [RUN_W-1:0]  cover_run_o,
    output logic [CNT_W-1:0]  fail_cnt_o,
    output logic [CNT_W-1:0]  pass_cnt_o,
    output logic [CNT_W-1:0]  abort_cnt_o,
    output logic [CNT_W-1:0]  cover_cnt_o,
    output logic              first_fail_valid_o,
    output logic [31:0]       first_fail_cyc_o
);

    logic             pending;
    logic             start;
    logic             early_abort;
    logic             run_step;
    logic             hit;
    logic [1:0]       abort_inc;
    logic [RUN_W-1:0] run;
    resolution_e      res;

    // Decide this sample's attempt start, resolution of the pending attempt and cover match.
    always_comb begin
        start       = hs.en & hs.req & ~hs.intr;
        early_abort = hs.en & hs.req & hs.intr;
        run_step    = hs.en & hs.req;
        hit         = hs.en & hs.ack & (run != '0);
        res         = NONE;
        if (pending) begin
            if (hs.intr) begin
                res = ABORT;
            end else if (hs.ack) begin
                res = PASS;
            end else begin
                res = FAIL;
            end
        end
        abort_inc = event_count(res == ABORT, early_abort);
    end

    // Register the pending attempt, the event pulses and the run length of the latest hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending       <= 1'b0;
            assert_pass_o <= 1'b0;
            assert_fail_o <= 1'b0;
            cover_hit_o   <= 1'b0;
            cover_run_o   <= '0;
        end else begin
            pending       <= start;
            assert_pass_o <= (res == PASS);
            assert_fail_o <= (res == FAIL);
            cover_hit_o   <= hit;
            if (hit) begin
                cover_run_o <= run;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_fail_cnt (
        .clk(clk), .rst(rst), .inc({1'b0, res == FAIL}), .clr(1'b0), .value(fail_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_pass_cnt (
        .clk(clk), .rst(rst), .inc({1'b0, res == PASS}), .clr(1'b0), .value(pass_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_abort_cnt (
        .clk(clk), .rst(rst), .inc(abort_inc), .clr(1'b0), .value(abort_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_cover_cnt (
        .clk(clk), .rst(rst), .inc({1'b0, hit}), .clr(1'b0), .value(cover_cnt_o)
    );

    sat_counter #(.W(RUN_W)) u_run_cnt (
        .clk(clk), .rst(rst), .inc({1'b0, run_step}), .clr(~run_step), .value(run)
    );

`ifdef REQ_ACK_CHECKER_FAIL_LOG_EN
    logic [31:0] cyc_cnt;

    // Free-running cycle count; capture it once, at the first failure after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt            <= '0;
            first_fail_valid_o <= 1'b0;
            first_fail_cyc_o   <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if ((res == FAIL) && !first_fail_valid_o) begin
                first_fail_valid_o <= 1'b1;
                first_fail_cyc_o   <= cyc_cnt;
            end
        end
    end
`else
    assign first_fail_valid_o = 1'b0;
    assign first_fail_cyc_o   = '0;
`endif

endmodule

// File: tb/tb_req_ack_checker.sv
// tb_req_ack_checker: table of directed vectors, hand-written saturation
// sequences and a randomized run against a history-based reference model.
module tb_req_ack_checker;
    import req_ack_checker_pkg::*;

    localparam int CW = CNT_W_DEF;
    localparam int RW = RUN_W_DEF;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    req_ack_checker_if hs();

    logic          a_fail, a_pass, a_hit, a_ffv;
    logic [RW-1:0] a_run;
    logic [CW-1:0] a_fc, a_pc, a_ac, a_cc;
    logic [31:0]   a_ffc;

    logic          b_fail, b_pass, b_hit, b_ffv;
    logic [RW-1:0] b_run;
    logic [SW-1:0] b_fc, b_pc, b_ac, b_cc;
    logic [31:0]   b_ffc;

    req_ack_checker #(.CNT_W(CW), .RUN_W(RW)) dut (
        .clk(clk), .rst(rst), .hs(hs),
        .assert_fail_o(a_fail), .assert_pass_o(a_pass), .cover_hit_o(a_hit),
        .cover_run_o(a_run), .fail_cnt_o(a_fc), .pass_cnt_o(a_pc),
        .abort_cnt_o(a_ac), .cover_cnt_o(a_cc),
        .first_fail_valid_o(a_ffv), .first_fail_cyc_o(a_ffc)
    );

    req_ack_checker #(.CNT_W(SW), .RUN_W(RW)) dut_small (
        .clk(clk), .rst(rst), .hs(hs),
        .assert_fail_o(b_fail), .assert_pass_o(b_pass), .cover_hit_o(b_hit),
        .cover_run_o(b_run), .fail_cnt_o(b_fc), .pass_cnt_o(b_pc),
        .abort_cnt_o(b_ac), .cover_cnt_o(b_cc),
        .first_fail_valid_o(b_ffv), .first_fail_cyc_o(b_ffc)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic rst, en, req, ack, intr;
        logic pass, fail, hit;
        int   crun, pc, fc, ac, cc;
    } vec_t;

    typedef struct {
        logic rst, en, req, ack, intr;
    } sample_t;

    vec_t vecs[$];

    // reference model state: what happened, not how the RTL stores it
    bit      hist[$];
    bit      last_ok;
    sample_t last;
    bit      m_pass, m_fail, m_hit, m_ffv;
    longint  m_crun, m_pc, m_fc, m_ac, m_cc, m_cyc, m_ffc;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic q, input logic a, input logic i);
        rst     = r;
        hs.en   = e;
        hs.req  = q;
        hs.ack  = a;
        hs.intr = i;
        @(posedge clk);
        #1;
    endtask

    function automatic void addVec(input logic r, input logic e, input logic q, input logic a, input logic i,
                                   input logic p, input logic f, input logic h,
                                   input int cr, input int pc, input int fc, input int ac, input int cc);
        vec_t v;
        v.rst = r; v.en = e; v.req = q; v.ack = a; v.intr = i;
        v.pass = p; v.fail = f; v.hit = h;
        v.crun = cr; v.pc = pc; v.fc = fc; v.ac = ac; v.cc = cc;
        vecs.push_back(v);
    endfunction

    function automatic longint sat(input longint x, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (x > mx) ? mx : x;
    endfunction

    task automatic modelSample(input sample_t s);
        int run;
        m_pass = 0;
        m_fail = 0;
        m_hit  = 0;
        if (s.rst) begin
            hist.delete();
            last_ok = 0;
            m_crun = 0; m_pc = 0; m_fc = 0; m_ac = 0; m_cc = 0;
            m_cyc = 0; m_ffv = 0; m_ffc = 0;
        end else begin
            if (last_ok && last.en && last.req && !last.intr) begin
                if (s.intr) begin
                    m_ac++;
                end else if (s.ack) begin
                    m_pass = 1;
                    m_pc++;
                end else begin
                    m_fail = 1;
                    m_fc++;
                    if (!m_ffv) begin
                        m_ffv = 1;
                        m_ffc = m_cyc;
                    end
                end
            end
            if (s.en && s.req && s.intr) m_ac++;
            run = 0;
            for (int k = hist.size() - 1; k >= 0; k--) begin
                if (!hist[k]) break;
                run++;
            end
            run = int'(sat(run, RW));
            if (s.en && s.ack && run > 0) begin
                m_hit  = 1;
                m_crun = run;
                m_cc++;
            end
            hist.push_back(s.en && s.req);
            if (hist.size() > 300) void'(hist.pop_front());
            last    = s;
            last_ok = 1;
            m_cyc   = (m_cyc + 1) % (longint'(1) << 32);
        end
    endtask

    task automatic modelStep(input sample_t s);
        logic          exp_ffv;
        logic [31:0]   exp_ffc;
        applyStimulus(s.rst, s.en, s.req, s.ack, s.intr);
        modelSample(s);
`ifdef REQ_ACK_CHECKER_FAIL_LOG_EN
        exp_ffv = m_ffv;
        exp_ffc = 32'(m_ffc);
`else
        exp_ffv = 1'b0;
        exp_ffc = 32'd0;
`endif
        checkOutput("rnd.pass",     a_pass, m_pass);
        checkOutput("rnd.fail",     a_fail, m_fail);
        checkOutput("rnd.hit",      a_hit,  m_hit);
        checkOutput("rnd.run",      a_run,  m_crun);
        checkOutput("rnd.pass_cnt", a_pc,   sat(m_pc, CW));
        checkOutput("rnd.fail_cnt", a_fc,   sat(m_fc, CW));
        checkOutput("rnd.abort_cnt", a_ac,  sat(m_ac, CW));
        checkOutput("rnd.cover_cnt", a_cc,  sat(m_cc, CW));
        checkOutput("rnd.ff_valid", a_ffv,  exp_ffv);
        checkOutput("rnd.ff_cyc",   a_ffc,  exp_ffc);
        checkOutput("rnd.small_fail_cnt",  b_fc, sat(m_fc, SW));
        checkOutput("rnd.small_pass_cnt",  b_pc, sat(m_pc, SW));
        checkOutput("rnd.small_abort_cnt", b_ac, sat(m_ac, SW));
        checkOutput("rnd.small_cover_cnt", b_cc, sat(m_cc, SW));
    endtask

    initial begin
        sample_t s;
        vec_t    v;

        rst = 1'b1; hs.en = 1'b0; hs.req = 1'b0; hs.ack = 1'b0; hs.intr = 1'b0;

        //      rst en req ack intr | pass fail hit | crun pc fc ac cc
        addVec(1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
        addVec(0, 1, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
        addVec(0, 1, 1, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
        addVec(0, 1, 0, 1, 0,  1, 0, 1,  1, 1, 0, 0, 1);
        addVec(0, 1, 0, 0, 0,  0, 0, 0,  1, 1, 0, 0, 1);
        addVec(0, 1, 1, 0, 0,  0, 0, 0,  1, 1, 0, 0, 1);
        addVec(0, 1, 0, 0, 0,  0, 1, 0,  1, 1, 1, 0, 1);
        addVec(0, 1, 0, 0, 0,  0, 0, 0,  1, 1, 1, 0, 1);
        addVec(0, 1, 1, 0, 0,  0, 0, 0,  1, 1, 1, 0, 1);
        addVec(0, 1, 0, 0, 1,  0, 0, 0,  1, 1, 1, 1, 1);
        addVec(0, 1, 1, 0, 1,  0, 0, 0,  1, 1, 1, 2, 1);
        addVec(0, 1, 0, 0, 0,  0, 0, 0,  1, 1, 1, 2, 1);
        addVec(0, 1, 1, 0, 0,  0, 0, 0,  1, 1, 1, 2, 1);
        addVec(0, 1, 1, 0, 0,  0, 1, 0,  1, 1, 2, 2, 1);
        addVec(0, 1, 1, 0, 0,  0, 1, 0,  1, 1, 3, 2, 1);
        addVec(0, 1, 0, 1, 0,  1, 0, 1,  3, 2, 3, 2, 2);
        addVec(0, 1, 0, 0, 0,  0, 0, 0,  3, 2, 3, 2, 2);
        addVec(0, 1, 1, 0, 0,  0, 0, 0,  3, 2, 3, 2, 2);
        addVec(0, 1, 1, 1, 0,  1, 0, 1,  1, 3, 3, 2, 3);
        addVec(0, 1, 0, 1, 0,  1, 0, 1,  2, 4, 3, 2, 4);
        addVec(0, 0, 1, 0, 0,  0, 0, 0,  2, 4, 3, 2, 4);
        addVec(0, 0, 0, 1, 0,  0, 0, 0,  2, 4, 3, 2, 4);
        addVec(0, 1, 1, 0, 0,  0, 0, 0,  2, 4, 3, 2, 4);
        addVec(1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
        addVec(0, 1, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);

        $display("[TB] directed vectors: %0d", vecs.size());
        for (int k = 0; k < vecs.size(); k++) begin
            v = vecs[k];
            applyStimulus(v.rst, v.en, v.req, v.ack, v.intr);
            checkOutput($sformatf("vec%0d.pass", k),      a_pass, v.pass);
            checkOutput($sformatf("vec%0d.fail", k),      a_fail, v.fail);
            checkOutput($sformatf("vec%0d.hit", k),       a_hit,  v.hit);
            checkOutput($sformatf("vec%0d.run", k),       a_run,  v.crun);
            checkOutput($sformatf("vec%0d.pass_cnt", k),  a_pc,   v.pc);
            checkOutput($sformatf("vec%0d.fail_cnt", k),  a_fc,   v.fc);
            checkOutput($sformatf("vec%0d.abort_cnt", k), a_ac,   v.ac);
            checkOutput($sformatf("vec%0d.cover_cnt", k), a_cc,   v.cc);
        end

        // six back-to-back attempts with no ack: six failures, small counter stops at 3
        $display("[TB] counter saturation sequence");
        applyStimulus(1, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("sat.fail_cnt",       a_fc, 6);
        checkOutput("sat.small_fail_cnt", b_fc, 3);
        checkOutput("sat.small_pass_cnt", b_pc, 0);

        // 300 req samples then ack: run report clamps at 255
        $display("[TB] run length saturation sequence");
        applyStimulus(1, 0, 0, 0, 0);
        for (int k = 0; k < 300; k++) applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 0, 1, 0);
        checkOutput("runsat.hit",            a_hit, 1);
        checkOutput("runsat.run",            a_run, 255);
        checkOutput("runsat.fail_cnt",       a_fc,  299);
        checkOutput("runsat.pass",           a_pass, 1);
        checkOutput("runsat.small_fail_cnt", b_fc,  3);

        $display("[TB] randomized run");
        s.rst = 1; s.en = 0; s.req = 0; s.ack = 0; s.intr = 0;
        modelStep(s);
        for (int k = 0; k < 3000; k++) begin
            s.rst  = ($urandom_range(0, 99) == 0);
            s.en   = ($urandom_range(0, 9) != 0);
            s.req  = 1'($urandom_range(0, 1));
            s.ack  = 1'($urandom_range(0, 1));
            s.intr = ($urandom_range(0, 7) == 0);
            modelStep(s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
